serial_paralelo: RTL

- Receive-side deserializer of the PHY: takes the 10b serial bitstream (LSB-first, one bit per CLOCK) and rebuilds 10-bit symbols for the downstream 10b/8b decoder.
- Aligns symbol boundaries on the K28.5 comma.
- Qualifies lock after LOCK_COUNT consecutive boundary commas.
- Re-aligns automatically when a comma appears off-boundary.

---
 rtl/serial_paralelo_pkg.sv | 23 ++
 rtl/serial_paralelo_detector_coma.sv | 17 +
 rtl/serial_paralelo.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/serial_paralelo_pkg.sv
// Shared PHY definitions for the receive deserializer: K28.5 comma codes,
// symbol framing constants and the aligner state encoding.
package serial_paralelo_pkg;

    localparam logic [9:0] K28_5_NEG = 10'h17C;
    localparam logic [9:0] K28_5_POS = 10'h283;

    localparam int unsigned SYM_BITS = 10;
    localparam logic [3:0]  LAST_BIT = 4'(SYM_BITS - 1);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    function automatic logic is_comma(input logic [9:0] sym,
                                      input logic [9:0] neg,
                                      input logic [9:0] pos);
        return (sym == neg) || (sym == pos);
    endfunction

endpackage

// File: rtl/serial_paralelo_detector_coma.sv
// Combinational K28.5 detector: flags a 10-bit window equal to either
// running-disparity form of the comma.
module detector_coma
    import serial_paralelo_pkg::*;
#(
    parameter logic [9:0] COMMA_NEG = K28_5_NEG,
    parameter logic [9:0] COMMA_POS = K28_5_POS
) (
    input  logic [9:0] sym_i,
    output logic       match_o
);

    always_comb begin
        match_o = is_comma(sym_i, COMMA_NEG, COMMA_POS);
    end

endmodule

// File: rtl/serial_paralelo.sv
// Receive deserializer: shifts in LSB-first serial bits, aligns symbol
// boundaries on K28.5 and reports lock after LOCK_COUNT boundary commas.
module serial_paralelo
    import serial_paralelo_pkg::*;
#(
    parameter logic [9:0]  COMMA_NEG  = K28_5_NEG,
    parameter logic [9:0]  COMMA_POS  = K28_5_POS,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic       CLOCK,
    input  logic       RESET_L,
    input  logic       ENABLE,
    input  logic       IS,
    output logic [9:0] D_OUT,
    output logic       VALID,
    output logic       COMMA,
    output logic       ALIGNED
);

    localparam logic [2:0] LOCK_CNT = 3'(LOCK_COUNT);

    logic [9:0] sr_q, sr_d, sr_shift;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [2:0] comma_cnt_q, comma_cnt_d;
    logic [2:0] comma_cnt_inc;
    state_e     state_q, state_d;
    logic [9:0] dout_q, dout_d;
    logic       valid_q, valid_d;
    logic       comma_q, comma_d;
    logic       aligned_q, aligned_d;
    logic       match;
    logic       boundary;

    assign sr_shift      = {IS, sr_q[9:1]};
    assign comma_cnt_inc = comma_cnt_q + 3'd1;

    detector_coma #(
        .COMMA_NEG (COMMA_NEG),
        .COMMA_POS (COMMA_POS)
    ) u_detector_coma (
        .sym_i   (sr_shift),
        .match_o (match)
    );

    always_comb begin
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        comma_cnt_d = comma_cnt_q;
        state_d     = state_q;
        dout_d      = dout_q;
        valid_d     = 1'b0;
        comma_d     = 1'b0;
        boundary    = 1'b0;

        if (ENABLE) begin
            sr_d      = sr_shift;
            boundary  = (bit_cnt_q == LAST_BIT) && (state_q != ST_SEARCH);
            bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + 4'd1;

            case (state_q)
                ST_SEARCH: begin
                    if (match) begin
                        bit_cnt_d   = '0;
                        comma_cnt_d = 3'd1;
                        dout_d      = sr_shift;
                        valid_d     = 1'b1;
                        comma_d     = 1'b1;
                        state_d     = (LOCK_CNT <= 3'd1) ? ST_LOCKED : ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (boundary) begin
                        dout_d  = sr_shift;
                        valid_d = 1'b1;
                        comma_d = match;
                        if (match) begin
                            comma_cnt_d = comma_cnt_inc;
                            if (comma_cnt_inc >= LOCK_CNT)
                                state_d = ST_LOCKED;
                        end
                    end else if (match) begin
                        // Off-boundary comma: restart framing from this symbol
                        bit_cnt_d   = '0;
                        comma_cnt_d = 3'd1;
                        dout_d      = sr_shift;
                        valid_d     = 1'b1;
                        comma_d     = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (boundary) begin
                        dout_d  = sr_shift;
                        valid_d = 1'b1;
                        comma_d = match;
                    end else if (match) begin
                        bit_cnt_d   = '0;
                        comma_cnt_d = 3'd1;
                        dout_d      = sr_shift;
                        valid_d     = 1'b1;
                        comma_d     = 1'b1;
                        state_d     = ST_CHECK;
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end

        aligned_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_L) begin
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            comma_cnt_q <= '0;
            state_q     <= ST_SEARCH;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            comma_q     <= 1'b0;
            aligned_q   <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            state_q     <= state_d;
            dout_q      <= dout_d;
            valid_q     <= valid_d;
            comma_q     <= comma_d;
            aligned_q   <= aligned_d;
        end
    end

    assign D_OUT   = dout_q;
    assign VALID   = valid_q;
    assign COMMA   = comma_q;
    assign ALIGNED = aligned_q;

endmodule
